// File: rtl/sie_ignition_detector_pkg.sv
// ============================================================================
// sie_ignition_detector_pkg
// Shared Q14 fixed-point constants and ignition FSM encoding.
// Rev 1.0
// ============================================================================
`default_nettype none

package sie_ignition_detector_pkg;

    localparam int Q14_FRAC = 14;
    localparam int Q14_ONE  = 16384;
    localparam int Q14_HALF = 8192;
    localparam int Q14_0P4  = 6554;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ONSET      = 2'd1,
        ST_IGNITED    = 2'd2,
        ST_REFRACTORY = 2'd3
    } ign_state_e;

endpackage

`default_nettype wire

// File: rtl/sie_ignition_detector.sv
// ============================================================================
// sie_ignition_detector
// Hysteretic ignition detector on smoothed bicoherence with one-entry skid record.
// Rev 1.0
// ============================================================================
`default_nettype none

module sie_ignition_detector
    import sie_ignition_detector_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int ON_THRESH  = Q14_HALF,
    parameter int OFF_THRESH = Q14_0P4,
    parameter int MIN_ON     = 4,
    parameter int REFRACT    = 16,
    parameter int DUR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] bicoherence,
    output logic             ignition,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_peak,
    output logic [DUR_W-1:0] evt_duration,
    output logic [15:0]      evt_count,
    output logic             evt_dropped
);

    localparam int ONW  = (MIN_ON  > 1) ? $clog2(MIN_ON)  : 1;
    localparam int REFW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    localparam logic signed [WIDTH-1:0] c_on_thr  = WIDTH'(ON_THRESH);
    localparam logic signed [WIDTH-1:0] c_off_thr = WIDTH'(OFF_THRESH);

    ign_state_e              r_state, w_state_nxt;
    logic [ONW-1:0]          r_onset_cnt, w_onset_nxt;
    logic [REFW-1:0]         r_refr_cnt, w_refr_nxt;
    logic signed [WIDTH-1:0] r_peak, w_peak_nxt;
    logic [DUR_W-1:0]        r_dur, w_dur_nxt;
    logic                    w_complete;
    logic                    r_ignition;

    logic                    r_evt_valid;
    logic [WIDTH-1:0]        r_evt_peak;
    logic [DUR_W-1:0]        r_evt_dur;
    logic [15:0]             r_evt_count;
    logic                    r_evt_dropped;

    logic signed [WIDTH-1:0] w_sample;
    logic                    w_above_on;
    logic                    w_above_off;

    assign w_sample    = $signed(bicoherence);
    assign w_above_on  = (w_sample >= c_on_thr);
    assign w_above_off = (w_sample >= c_off_thr);

    always_comb begin
        w_state_nxt = r_state;
        w_onset_nxt = r_onset_cnt;
        w_refr_nxt  = r_refr_cnt;
        w_peak_nxt  = r_peak;
        w_dur_nxt   = r_dur;
        w_complete  = 1'b0;
        if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_above_on) begin
                        if (MIN_ON == 1) begin
                            w_state_nxt = ST_IGNITED;
                            w_peak_nxt  = w_sample;
                            w_dur_nxt   = DUR_W'(1);
                        end else begin
                            w_state_nxt = ST_ONSET;
                            w_onset_nxt = ONW'(1);
                        end
                    end
                end
                ST_ONSET: begin
                    if (w_above_on) begin
                        if (r_onset_cnt == ONW'(MIN_ON - 1)) begin
                            w_state_nxt = ST_IGNITED;
                            w_onset_nxt = '0;
                            w_peak_nxt  = w_sample;
                            w_dur_nxt   = DUR_W'(1);
                        end else begin
                            w_onset_nxt = r_onset_cnt + ONW'(1);
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_onset_nxt = '0;
                    end
                end
                ST_IGNITED: begin
                    if (w_above_off) begin
                        if (r_dur != '1) begin
                            w_dur_nxt = r_dur + DUR_W'(1);
                        end
                        if (w_sample > r_peak) begin
                            w_peak_nxt = w_sample;
                        end
                    end else begin
                        // The falling sample is not part of the event.
                        w_state_nxt = ST_REFRACTORY;
                        w_refr_nxt  = '0;
                        w_complete  = 1'b1;
                    end
                end
                ST_REFRACTORY: begin
                    if (r_refr_cnt == REFW'(REFRACT - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_refr_nxt  = '0;
                    end else begin
                        w_refr_nxt = r_refr_cnt + REFW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_onset_cnt <= '0;
            r_refr_cnt  <= '0;
            r_peak      <= '0;
            r_dur       <= '0;
            r_ignition  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_onset_cnt <= w_onset_nxt;
            r_refr_cnt  <= w_refr_nxt;
            r_peak      <= w_peak_nxt;
            r_dur       <= w_dur_nxt;
            r_ignition  <= (w_state_nxt == ST_IGNITED);
        end
    end

    // Skid register: a completion may overwrite only a slot that is empty or
    // being drained on this very edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_valid   <= 1'b0;
            r_evt_peak    <= '0;
            r_evt_dur     <= '0;
            r_evt_count   <= '0;
            r_evt_dropped <= 1'b0;
        end else begin
            if (w_complete) begin
                r_evt_count <= r_evt_count + 16'd1;
                if (!r_evt_valid || evt_ready) begin
                    r_evt_valid <= 1'b1;
                    r_evt_peak  <= r_peak;
                    r_evt_dur   <= r_dur;
                end else begin
                    r_evt_dropped <= 1'b1;
                end
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign ignition     = r_ignition;
    assign evt_valid    = r_evt_valid;
    assign evt_peak     = r_evt_peak;
    assign evt_duration = r_evt_dur;
    assign evt_count    = r_evt_count;
    assign evt_dropped  = r_evt_dropped;

endmodule

`default_nettype wire

// File: tb/tb_sie_ignition_detector.sv
// ============================================================================
// tb_sie_ignition_detector
// Scoreboard bench for the ignition detector: expected records queued at stimulus.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sie_ignition_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [17:0] bicoherence;
    logic        ignition;
    logic        evt_valid;
    logic        evt_ready;
    logic [17:0] evt_peak;
    logic [15:0] evt_duration;
    logic [15:0] evt_count;
    logic        evt_dropped;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [17:0] peak;
        logic [15:0] dur;
    } rec_t;

    rec_t sb_q[$];

    always #5 clk = ~clk;

    sie_ignition_detector #(
        .WIDTH      (18),
        .ON_THRESH  (8192),
        .OFF_THRESH (6554),
        .MIN_ON     (4),
        .REFRACT    (16),
        .DUR_W      (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .bicoherence  (bicoherence),
        .ignition     (ignition),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_peak     (evt_peak),
        .evt_duration (evt_duration),
        .evt_count    (evt_count),
        .evt_dropped  (evt_dropped)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int s, input logic en);
        @(negedge clk);
        bicoherence = 18'(s);
        clk_en      = en;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n, input int s);
        for (int i = 0; i < n; i++) step(s, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        clk_en      = 1'b0;
        evt_ready   = 1'b0;
        bicoherence = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sb_push(input int peak, input int dur);
        rec_t r;
        r.peak = 18'(peak);
        r.dur  = 16'(dur);
        sb_q.push_back(r);
    endtask

    task automatic sb_pop();
        rec_t r;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            r = sb_q.pop_front();
            chk("rec_valid", 32'(evt_valid), 32'd1);
            chk("rec_peak", 32'(evt_peak), 32'(r.peak));
            chk("rec_dur", 32'(evt_duration), 32'(r.dur));
        end
    endtask

    initial begin
        rst         = 1'b1;
        clk_en      = 1'b0;
        evt_ready   = 1'b0;
        bicoherence = '0;
        do_reset();
        #1;
        chk("rst_ign", 32'(ignition), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_peak", 32'(evt_peak), 32'd0);
        chk("rst_dur", 32'(evt_duration), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_drop", 32'(evt_dropped), 32'd0);

        // Basic event: ignition after the 4th qualifying sample.
        strobes(3, 9000);
        chk("basic_pre_ign", 32'(ignition), 32'd0);
        step(9000, 1'b1);
        chk("basic_ign", 32'(ignition), 32'd1);
        strobes(3, 7000);
        chk("basic_hold_ign", 32'(ignition), 32'd1);
        sb_push(9000, 4);
        step(5000, 1'b1);
        chk("basic_valid", 32'(evt_valid), 32'd1);
        chk("basic_ign_off", 32'(ignition), 32'd0);
        chk("basic_count", 32'(evt_count), 32'd1);
        sb_pop();
        evt_ready = 1'b1;
        step(0, 1'b0);
        evt_ready = 1'b0;
        chk("basic_drain", 32'(evt_valid), 32'd0);
        strobes(16, 0);

        // Short burst never ignites, and the onset count is really cleared.
        strobes(3, 9000);
        chk("short_ign", 32'(ignition), 32'd0);
        step(4000, 1'b1);
        strobes(3, 9000);
        chk("short_ign2", 32'(ignition), 32'd0);
        chk("short_count", 32'(evt_count), 32'd1);
        chk("short_valid", 32'(evt_valid), 32'd0);

        // Drop: second completion while first record is still held.
        do_reset();
        strobes(4, 9000);
        step(10000, 1'b1);
        step(8000, 1'b1);
        sb_push(10000, 3);
        step(0, 1'b1);
        chk("drop_first_valid", 32'(evt_valid), 32'd1);
        strobes(16, 0);
        strobes(4, 12000);
        step(0, 1'b1);
        chk("drop_count", 32'(evt_count), 32'd2);
        chk("drop_flag", 32'(evt_dropped), 32'd1);
        sb_pop();
        evt_ready = 1'b1;
        step(0, 1'b0);
        evt_ready = 1'b0;
        chk("drop_drain", 32'(evt_valid), 32'd0);
        chk("drop_sticky", 32'(evt_dropped), 32'd1);
        do_reset();
        #1;
        chk("drop_clear_rst", 32'(evt_dropped), 32'd0);

        // Completion on the same edge the held record is accepted.
        strobes(4, 9000);
        sb_push(9000, 1);
        step(0, 1'b1);
        strobes(16, 0);
        strobes(4, 9500);
        step(11000, 1'b1);
        sb_pop();
        sb_push(11000, 2);
        evt_ready = 1'b1;
        step(0, 1'b1);
        evt_ready = 1'b0;
        chk("swap_drop", 32'(evt_dropped), 32'd0);
        chk("swap_count", 32'(evt_count), 32'd2);
        sb_pop();
        evt_ready = 1'b1;
        step(0, 1'b0);
        evt_ready = 1'b0;
        chk("swap_drain", 32'(evt_valid), 32'd0);

        // Gapped strobes, negative samples and refractory length.
        do_reset();
        step(9000, 1'b1);
        step(-100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(9000, 1'b1);
            chk("gap_ign", 32'(ignition), 32'(i == 3));
            step(-100, 1'b0);
            chk("gap_frozen", 32'(ignition), 32'(i == 3));
            step(-100, 1'b0);
        end
        sb_push(9000, 1);
        step(-100, 1'b1);
        chk("gap_cmp_ign", 32'(ignition), 32'd0);
        chk("gap_count", 32'(evt_count), 32'd1);
        sb_pop();
        evt_ready = 1'b1;
        step(20000, 1'b0);
        evt_ready = 1'b0;
        chk("gap_hs_noen", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(20000, 1'b1);
            step(20000, 1'b0);
        end
        chk("refr_ign", 32'(ignition), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(20000, 1'b1);
            chk("refr_len", 32'(ignition), 32'(i == 3));
            step(0, 1'b0);
        end

        // Asynchronous reset while IGNITED, between clock edges.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ign", 32'(ignition), 32'd0);
        chk("arst_count", 32'(evt_count), 32'd0);
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_peak", 32'(evt_peak), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        strobes(20, 0);
        chk("arst_no_rec", 32'(evt_valid), 32'd0);
        chk("arst_no_cnt", 32'(evt_count), 32'd0);

        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
